// File: rtl/ddr3_wb_arbiter.sv
// Shares the pipelined Wishbone port of ddr3_top between NREQ requesters; acks are routed back via an in-order tag FIFO.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest) instead of round-robin.
module ddr3_wb_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 128,
    parameter int AUX_WIDTH = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                            i_controller_clk,
    input  logic                            i_rst_n,
    input  logic [NREQ-1:0]                 i_req_cyc,
    input  logic [NREQ-1:0]                 i_req_stb,
    input  logic [NREQ-1:0]                 i_req_we,
    input  logic [NREQ*ADDR_BITS-1:0]       i_req_addr,
    input  logic [NREQ*DATA_BITS-1:0]       i_req_data,
    input  logic [NREQ*(DATA_BITS/8)-1:0]   i_req_sel,
    input  logic [NREQ*AUX_WIDTH-1:0]       i_req_aux,
    output logic [NREQ-1:0]                 o_req_stall,
    output logic [NREQ-1:0]                 o_req_ack,
    output logic [DATA_BITS-1:0]            o_req_data,
    output logic [AUX_WIDTH-1:0]            o_req_aux,
    output logic                            o_wb_cyc,
    output logic                            o_wb_stb,
    output logic                            o_wb_we,
    output logic [ADDR_BITS-1:0]            o_wb_addr,
    output logic [DATA_BITS-1:0]            o_wb_data,
    output logic [DATA_BITS/8-1:0]          o_wb_sel,
    output logic [AUX_WIDTH-1:0]            o_wb_aux,
    input  logic                            i_wb_stall,
    input  logic                            i_wb_ack,
    input  logic [DATA_BITS-1:0]            i_wb_data,
    input  logic [AUX_WIDTH-1:0]            i_wb_aux,
    output logic [$clog2(TAG_DEPTH):0]      o_outstanding,
    output logic                            o_err_ack
);
    localparam int SEL_BITS = DATA_BITS / 8;
    localparam int ID_W     = $clog2(NREQ);
    localparam int PTR_W    = $clog2(TAG_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [NREQ-1:0]  req_valid;
    logic             grant_valid;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  head;
    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             pop;

    assign req_valid  = i_req_cyc & i_req_stb;
    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];
    assign accept     = o_wb_stb && !i_wb_stall;
    assign pop        = i_rst_n && i_wb_ack && !fifo_empty;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            idx = i;
`else
            idx = (int'(rr_ptr) + i) % NREQ;
`endif
            if (!grant_valid && req_valid[ID_W'(idx)]) begin
                grant_valid = 1'b1;
                grant       = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_err_ack <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_wb_ack && fifo_empty) o_err_ack <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge i_controller_clk) begin
        if (accept) tag_mem[wr_ptr] <= grant;
    end

    always_comb begin
        o_wb_stb  = i_rst_n && (|req_valid) && !fifo_full;
        o_wb_cyc  = i_rst_n && ((|i_req_cyc) || !fifo_empty);
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        o_wb_aux  = '0;
        if (grant_valid) begin
            o_wb_we   = i_req_we[grant];
            o_wb_addr = i_req_addr[grant*ADDR_BITS +: ADDR_BITS];
            o_wb_data = i_req_data[grant*DATA_BITS +: DATA_BITS];
            o_wb_sel  = i_req_sel[grant*SEL_BITS +: SEL_BITS];
            o_wb_aux  = i_req_aux[grant*AUX_WIDTH +: AUX_WIDTH];
        end
    end

    // Acks for requesters that have dropped cyc are still popped, just not forwarded.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            o_req_stall[k] = !(i_rst_n && grant_valid && (grant == ID_W'(k)) &&
                               !i_wb_stall && !fifo_full);
            o_req_ack[k]   = pop && (head == ID_W'(k)) && i_req_cyc[k];
        end
    end

    assign o_req_data    = i_wb_data;
    assign o_req_aux     = i_wb_aux;
    assign o_outstanding = count;

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Bench for ddr3_wb_arbiter: directed scenarios then random traffic, checked against a queue-based model.
module tb_ddr3_wb_arbiter;
    localparam int NREQ = 2;
    localparam int AB   = 24;
    localparam int DB   = 128;
    localparam int AW   = 4;
    localparam int TD   = 8;
    localparam int SB   = DB / 8;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_cyc, req_stb, req_we;
    logic [NREQ*AB-1:0]   req_addr;
    logic [NREQ*DB-1:0]   req_data;
    logic [NREQ*SB-1:0]   req_sel;
    logic [NREQ*AW-1:0]   req_aux;
    logic [NREQ-1:0]      req_stall, req_ack;
    logic [DB-1:0]        req_rdata;
    logic [AW-1:0]        req_raux;
    logic                 wb_cyc, wb_stb, wb_we;
    logic [AB-1:0]        wb_addr;
    logic [DB-1:0]        wb_wdata;
    logic [SB-1:0]        wb_sel;
    logic [AW-1:0]        wb_aux;
    logic                 wb_stall, wb_ack;
    logic [DB-1:0]        wb_rdata;
    logic [AW-1:0]        wb_raux;
    logic [$clog2(TD):0]  outstanding;
    logic                 err_ack;

    logic [AB-1:0] a [NREQ];
    logic [DB-1:0] d [NREQ];
    logic [SB-1:0] s [NREQ];
    logic [AW-1:0] x [NREQ];
    logic          w [NREQ];

    int q[$];
    int rr;
    bit err;
    int checks = 0;
    int errors = 0;

    assign req_addr = {a[1], a[0]};
    assign req_data = {d[1], d[0]};
    assign req_sel  = {s[1], s[0]};
    assign req_aux  = {x[1], x[0]};
    assign req_we   = {w[1], w[0]};

    ddr3_wb_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW), .TAG_DEPTH(TD)) dut (
        .i_controller_clk(clk),
        .i_rst_n(rst_n),
        .i_req_cyc(req_cyc),
        .i_req_stb(req_stb),
        .i_req_we(req_we),
        .i_req_addr(req_addr),
        .i_req_data(req_data),
        .i_req_sel(req_sel),
        .i_req_aux(req_aux),
        .o_req_stall(req_stall),
        .o_req_ack(req_ack),
        .o_req_data(req_rdata),
        .o_req_aux(req_raux),
        .o_wb_cyc(wb_cyc),
        .o_wb_stb(wb_stb),
        .o_wb_we(wb_we),
        .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata),
        .o_wb_sel(wb_sel),
        .o_wb_aux(wb_aux),
        .i_wb_stall(wb_stall),
        .i_wb_ack(wb_ack),
        .i_wb_data(wb_rdata),
        .i_wb_aux(wb_raux),
        .o_outstanding(outstanding),
        .o_err_ack(err_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_payload();
        for (int k = 0; k < NREQ; k++) begin
            a[k] = AB'($urandom);
            d[k] = {$urandom, $urandom, $urandom, $urandom};
            s[k] = SB'($urandom);
            x[k] = AW'($urandom);
            w[k] = 1'($urandom);
        end
    endtask

    // One controller cycle: drive at negedge, compare combinational outputs, then advance the model.
    task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic stall, input logic ack);
        int g;
        logic [1:0] valid, e_stall, e_ack;
        bit full, empty, pop, e_stb;
        req_cyc  = cyc;
        req_stb  = stb;
        wb_stall = stall;
        wb_ack   = ack;
        wb_rdata = {$urandom, $urandom, $urandom, $urandom};
        wb_raux  = AW'($urandom);
        #1;
        valid = cyc & stb;
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
`ifdef ARB_FIXED_PRIORITY_EN
            idx = i;
`else
            idx = (rr + i) % NREQ;
`endif
            if (g < 0 && valid[idx]) g = idx;
        end
        full  = (q.size() == TD);
        empty = (q.size() == 0);
        e_stb = (valid != 0) && !full;
        e_stall = 2'b11;
        if (g >= 0 && !stall && !full) e_stall[g] = 1'b0;
        pop = ack && !empty;
        e_ack = 2'b00;
        if (pop && cyc[q[0]]) e_ack[q[0]] = 1'b1;

        check("wb_stb", wb_stb, e_stb);
        check("wb_cyc", wb_cyc, (cyc != 0) || !empty);
        check("wb_addr", wb_addr, (g >= 0) ? a[g] : '0);
        check("wb_data", wb_wdata, (g >= 0) ? d[g] : '0);
        check("wb_we_sel_aux", {wb_we, wb_sel, wb_aux},
              (g >= 0) ? {w[g], s[g], x[g]} : '0);
        check("req_stall", req_stall, e_stall);
        check("req_ack", req_ack, e_ack);
        check("req_rdata", {req_rdata, req_raux}, {wb_rdata, wb_raux});
        check("outstanding", outstanding, q.size());
        check("err_ack", err_ack, err);

        if (ack && empty) err = 1'b1;
        if (pop) void'(q.pop_front());
        if (e_stb && !stall) begin
            q.push_back(g);
            rr = (g + 1) % NREQ;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        while (q.size() != 0) step(2'b11, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outstanding"}, outstanding, 0);
        check({tag, "_err_ack"}, err_ack, 1'b0);
        check({tag, "_stb_cyc"}, {wb_stb, wb_cyc}, 2'b00);
        check({tag, "_stall_ack"}, {req_stall, req_ack}, 4'b1100);
    endtask

    initial begin
        rst_n    = 1'b0;
        req_cyc  = '0;
        req_stb  = '0;
        wb_stall = 1'b0;
        wb_ack   = 1'b0;
        wb_rdata = '0;
        wb_raux  = '0;
        for (int k = 0; k < NREQ; k++) begin
            a[k] = '0; d[k] = '0; s[k] = '0; x[k] = '0; w[k] = 1'b0;
        end
        rr  = 0;
        err = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single write from requester 0, acked three cycles after accept
        w[0] = 1'b1; a[0] = 24'h10; d[0] = 128'hAA; s[0] = '1; x[0] = 4'h3;
        step(2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b1);
        step(2'b01, 2'b00, 1'b0, 1'b0);

        // both requesters streaming with no controller stall
        w[1] = 1'b0; a[1] = 24'h2000; d[1] = 128'h55;
        for (int i = 0; i < 10; i++) step(2'b11, 2'b11, 1'b0, i >= 2);
        drain();

        // fill the tag FIFO, then ack with a pending request
        for (int i = 0; i < TD + 1; i++) step(2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 2'b01, 1'b0, 1'b1);
        step(2'b01, 2'b01, 1'b0, 1'b0);
        drain();

        // requester 1 abandons two reads; their acks must be swallowed
        w[1] = 1'b0; a[1] = 24'h77;
        step(2'b10, 2'b10, 1'b0, 1'b0);
        step(2'b10, 2'b10, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        w[0] = 1'b0; a[0] = 24'h44;
        step(2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // stray ack sets the sticky error
        step(2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++) step(2'b01, 2'b01, 1'b0, 1'b0);
        req_cyc = '0;
        req_stb = '0;
        wb_ack  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        rr  = 0;
        err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            randomize_payload();
            step(2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                 (q.size() != 0) && ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_wb_arbiter.md
Name: ddr3_wb_arbiter

Overview:
- Shares the single pipelined Wishbone port of ddr3_top between NREQ requesters, e.g. the UART command path and a memory test pattern generator.
- Round-robin grant per request beat.
- Records the requester ID of every accepted beat in an in-order tag FIFO, then routes each o_wb_ack/o_wb_data/o_aux from the controller back to the requester that issued the beat.
- Sits between the requesters and the ddr3_top i_wb_* / o_wb_* pins, in the controller clock domain.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_BITS, 24, Wishbone address width
- DATA_BITS, 128, Wishbone data width
- AUX_WIDTH, 4, aux sideband width
- TAG_DEPTH, 8, outstanding-beat FIFO depth (power of 2, ≥2)

Ports:
- i_controller_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_cyc  in  NREQ  per-requester cyc
- i_req_stb  in  NREQ  per-requester stb
- i_req_we  in  NREQ  per-requester we
- i_req_addr  in  NREQ*ADDR_BITS  flattened; requester k at [k*ADDR_BITS +: ADDR_BITS]
- i_req_data  in  NREQ*DATA_BITS  flattened write data
- i_req_sel  in  NREQ*DATA_BITS/8  flattened byte strobes
- i_req_aux  in  NREQ*AUX_WIDTH  flattened aux
- o_req_stall  out  NREQ  per-requester stall
- o_req_ack  out  NREQ  per-requester ack
- o_req_data  out  DATA_BITS  read data, shared; valid for the requester whose ack is high
- o_req_aux  out  AUX_WIDTH  returned aux, shared
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  to controller
- o_wb_addr  out  ADDR_BITS  to controller
- o_wb_data  out  DATA_BITS  to controller
- o_wb_sel  out  DATA_BITS/8  to controller
- o_wb_aux  out  AUX_WIDTH  to controller
- i_wb_stall, i_wb_ack  in  1  from controller
- i_wb_data  in  DATA_BITS  from controller
- i_wb_aux  in  AUX_WIDTH  from controller
- o_outstanding  out  $clog2(TAG_DEPTH)+1  FIFO occupancy
- o_err_ack  out  1  sticky: ack received with FIFO empty

Behaviour:
- Clock/reset: one clock, i_controller_clk. i_rst_n is asynchronous, active-low.
- Reset state: FIFO empty, rr pointer = 0, o_outstanding = 0, o_err_ack = 0.
- Outputs in reset: o_wb_stb = 0, o_req_ack = 0, o_req_stall = all 1s, o_wb_cyc = 0.
- Valid request: k is valid when i_req_cyc[k] && i_req_stb[k].
- Grant (combinational): first valid k searching from rr pointer upward, modulo NREQ.
- Master outputs: o_wb_stb = any valid && !fifo_full. Remaining o_wb_* are muxed from the granted requester, forced to 0 when no grant.
- o_wb_cyc = (any i_req_cyc) || (o_outstanding != 0).
- Stall: o_req_stall[k] = !(grant==k && !i_wb_stall && !fifo_full). Non-granted requesters always stall.
- Accept: an accept is o_wb_stb && !i_wb_stall. Zero added latency requester→controller.
- On accept:
  - push the grant ID into the FIFO;
  - rr pointer <= grant+1 (mod NREQ).
- No accept: rr pointer holds.
- Return path (combinational, same cycle as i_wb_ack):
  - when i_wb_ack and FIFO non-empty, pop head h;
  - o_req_ack[h] = 1 only if i_req_cyc[h] is still high, otherwise the ack is discarded;
  - o_req_data = i_wb_data, o_req_aux = i_wb_aux (passed through unconditionally).
- Unexpected ack: i_wb_ack with FIFO empty sets o_err_ack (sticky until reset). No requester is acked.
- Occupancy: simultaneous push and pop leaves o_outstanding unchanged, with both pointers advancing. Pointers wrap modulo TAG_DEPTH.
- Full: fifo_full (o_outstanding == TAG_DEPTH) blocks all accepts. A pop in the same cycle does not unblock; the accept occurs the next cycle.
- Abort: if a requester drops cyc mid-transaction, its outstanding tags stay in the FIFO. Their acks are popped and discarded, and ordering for others is preserved.
- Reset asserted mid-operation clears the FIFO immediately. Acks arriving after reset release are treated as unexpected.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN
- Defined: grant is the lowest-index valid requester (requester 0 highest); the rr pointer is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester 0 writes addr 0x10, data 0xAA; controller acks 3 cycles later → o_req_ack[0] pulses once, o_req_ack[1] stays 0, o_outstanding goes 0→1→0.
- Both requesters hold stb continuously with i_wb_stall = 0 → accepts alternate 0,1,0,1; acks are returned in the same order to the matching requester.
- Controller withholds ack for TAG_DEPTH = 8 accepts → 9th beat is stalled, o_outstanding = 8. Ack plus pending stb in the same cycle → accept occurs the next cycle.
- Requester 1 issues 2 reads then drops cyc before the acks → both acks are discarded, a following requester 0 read is acked correctly, o_err_ack = 0.
- Ack with FIFO empty → o_err_ack = 1 and stays set. Deassert i_rst_n with 3 beats outstanding → o_outstanding = 0 immediately, o_err_ack cleared.
- With ARB_FIXED_PRIORITY_EN defined, both requesters continuously requesting → only requester 0 is granted until its stb drops.
